// File: rtl/score_hit_scheduler.sv
// Session sequencer and round-robin lane arbiter feeding the score counter.
// Hits queue per lane; one grant per cycle becomes a one-cycle o_Hit.
`timescale 1ns/1ps
module score_hit_scheduler #(
    parameter int          NUM_LANES  = 4,
    parameter logic [15:0] GAME_TICKS = 16'd30000,
    parameter logic [7:0]  DROP_MAX   = 8'd255
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Start,
    input  logic                 i_Tick,
    input  logic [NUM_LANES-1:0] i_LaneHit,
    output logic                 o_ResetScore,
    output logic                 o_Hit,
    output logic [1:0]           o_HitLane,
    output logic [2:0]           o_State,
    output logic                 o_Playing,
    output logic                 o_Done,
    output logic [15:0]          o_TicksLeft,
    output logic [7:0]           o_DropCnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        PLAY  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    logic [3:0]  pending;
    logic [1:0]  rr;
    logic        hit;
    logic [1:0]  hit_lane;
    logic [15:0] ticks_left;
    logic [7:0]  drop_cnt;

    logic        arb_en;
    logic [3:0]  rot;
    logic [1:0]  off;
    logic        grant_vld;
    logic [1:0]  grant_lane;
    logic [3:0]  grant_mask;
    logic [3:0]  drop_vec;
    logic [2:0]  drop_num;
    logic [8:0]  drop_sum;

    // Rotate so the rr lane sits at bit 0, then pick the lowest set bit.
    always_comb begin
        arb_en     = (state == PLAY) || (state == DRAIN);
        rot        = 4'({pending, pending} >> rr);
        off        = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot[k]) off = 2'(k);
        end
        grant_vld  = arb_en && (pending != 4'd0);
        grant_lane = rr + off;
        grant_mask = grant_vld ? (4'd1 << grant_lane) : 4'd0;
        drop_vec   = (state == PLAY) ? (i_LaneHit & pending & ~grant_mask)
                                     : 4'd0;
        drop_num   = 3'(drop_vec[0]) + 3'(drop_vec[1])
                   + 3'(drop_vec[2]) + 3'(drop_vec[3]);
        drop_sum   = {1'b0, drop_cnt} + {6'd0, drop_num};
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state      <= IDLE;
            pending    <= 4'd0;
            rr         <= 2'd0;
            hit        <= 1'b0;
            hit_lane   <= 2'd0;
            ticks_left <= 16'd0;
            drop_cnt   <= 8'd0;
        end else begin
            hit      <= grant_vld;
            hit_lane <= grant_vld ? grant_lane : 2'd0;
            if (grant_vld) rr <= grant_lane + 2'd1;
            unique case (state)
                IDLE: begin
                    if (i_Start) state <= CLEAR;
                end
                CLEAR: begin
                    state      <= PLAY;
                    pending    <= 4'd0;
                    drop_cnt   <= 8'd0;
                    ticks_left <= GAME_TICKS;
                    rr         <= 2'd0;
                end
                PLAY: begin
                    // A hit on a lane being granted this edge re-queues it.
                    pending  <= (pending & ~grant_mask) | i_LaneHit;
                    drop_cnt <= (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX
                                                              : drop_sum[7:0];
                    if (i_Tick) begin
                        ticks_left <= ticks_left - 16'd1;
                        if (ticks_left == 16'd1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    pending <= pending & ~grant_mask;
                    if (pending == 4'd0) state <= DONE;
                end
                DONE: begin
                    if (i_Start) state <= CLEAR;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ResetScore = (state == CLEAR);
    assign o_Hit        = hit;
    assign o_HitLane    = hit_lane;
    assign o_State      = state;
    assign o_Playing    = (state == PLAY);
    assign o_Done       = (state == DONE);
    assign o_TicksLeft  = ticks_left;
    assign o_DropCnt    = drop_cnt;

endmodule

// File: tb/tb_score_hit_scheduler.sv
// Bench for score_hit_scheduler: behavioural session/arbiter model checked
// every cycle, directed scenarios with literal expectations, random traffic.
`timescale 1ns/1ps
module tb_score_hit_scheduler;

    localparam logic [15:0] TB_TICKS = 16'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  lane_hit = 4'd0;
    logic        reset_score;
    logic        hit;
    logic [1:0]  hit_lane;
    logic [2:0]  state;
    logic        playing;
    logic        done;
    logic [15:0] ticks_left;
    logic [7:0]  drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int       m_state;
    bit [3:0] m_pend;
    int       m_rr;
    int       m_hit;
    int       m_lane;
    int       m_ticks;
    int       m_drop;

    score_hit_scheduler #(
        .NUM_LANES  (4),
        .GAME_TICKS (TB_TICKS),
        .DROP_MAX   (8'd255)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Start      (start),
        .i_Tick       (tick),
        .i_LaneHit    (lane_hit),
        .o_ResetScore (reset_score),
        .o_Hit        (hit),
        .o_HitLane    (hit_lane),
        .o_State      (state),
        .o_Playing    (playing),
        .o_Done       (done),
        .o_TicksLeft  (ticks_left),
        .o_DropCnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pend = 4'd0; m_rr = 0;
        m_hit = 0; m_lane = 0; m_ticks = 0; m_drop = 0;
    endtask

    // Next model state from current state and the inputs about to be sampled.
    task automatic model_step();
        bit       gv;
        int       g;
        int       n;
        bit [3:0] np;
        gv = 0; g = 0; n = 0;
        if ((m_state == 2 || m_state == 3) && m_pend != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                if (!gv && m_pend[(m_rr + k) % 4]) begin
                    gv = 1;
                    g  = (m_rr + k) % 4;
                end
            end
        end
        np = m_pend;
        if (gv) np[g] = 1'b0;
        case (m_state)
            0: if (start) m_state = 1;
            1: begin
                m_state = 2; np = 4'd0; m_drop = 0;
                m_ticks = int'(TB_TICKS); m_rr = 0;
            end
            2: begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_hit[i]) begin
                        if (m_pend[i] && !(gv && g == i)) n++;
                        np[i] = 1'b1;
                    end
                end
                m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
                if (tick) begin
                    m_ticks = m_ticks - 1;
                    if (m_ticks == 0) m_state = 3;
                end
            end
            3: if (m_pend == 4'd0) m_state = 4;
            4: if (start) m_state = 1;
            default: m_state = 0;
        endcase
        if (gv) m_rr = (g + 1) % 4;
        m_pend = np;
        m_hit  = gv ? 1 : 0;
        m_lane = gv ? g : 0;
    endtask

    task automatic compare_all();
        chk("state", state, m_state);
        chk("reset_score", reset_score, (m_state == 1) ? 1 : 0);
        chk("playing", playing, (m_state == 2) ? 1 : 0);
        chk("done", done, (m_state == 4) ? 1 : 0);
        chk("ticks_left", ticks_left, m_ticks);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("hit", hit, m_hit);
        chk("hit_lane", hit_lane, m_lane);
    endtask

    task automatic cyc(input logic s, input logic t, input logic [3:0] l);
        start = s; tick = t; lane_hit = l;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    int cnt;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("rst_state", state, 0);
        chk("rst_drop", drop_cnt, 0);
        rst = 1'b0;

        // Lane hits in IDLE do nothing.
        repeat (3) cyc(1'b0, 1'b0, 4'hF);
        chk("idle_hit", hit, 0);
        chk("idle_state", state, 0);

        // Session start: one CLEAR cycle then PLAY.
        cyc(1'b1, 1'b0, 4'h0);
        chk("clear_state", state, 1);
        chk("clear_pulse", reset_score, 1);
        cyc(1'b0, 1'b0, 4'h0);
        chk("play_state", state, 2);
        chk("play_ticks", ticks_left, 3);
        chk("play_flag", playing, 1);
        chk("clear_once", reset_score, 0);

        // All four lanes at once drain in order 0..3.
        cyc(1'b0, 1'b0, 4'hF);
        chk("latency", hit, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 4'h0);
            chk("rr_hit", hit, 1);
            chk("rr_lane", hit_lane, i);
        end
        cyc(1'b0, 1'b0, 4'h0);
        chk("rr_idle", hit, 0);
        chk("rr_drop", drop_cnt, 0);

        // Grant lane 1, then 0 and 2 together: 2 wins over 0.
        cyc(1'b0, 1'b0, 4'b0010);
        cyc(1'b0, 1'b0, 4'b0101);
        chk("g1_lane", hit_lane, 1);
        cyc(1'b0, 1'b0, 4'h0);
        chk("g2_lane", hit_lane, 2);
        cyc(1'b0, 1'b0, 4'h0);
        chk("g0_lane", hit_lane, 0);
        cyc(1'b0, 1'b0, 4'h0);
        chk("g_idle", hit, 0);

        // Second hit on a still-pending lane 3 is dropped.
        cyc(1'b0, 1'b0, 4'hF);
        cyc(1'b0, 1'b0, 4'b1000);
        chk("drop_one", drop_cnt, 1);
        cnt = 0;
        repeat (5) begin
            cyc(1'b0, 1'b0, 4'h0);
            if (hit && hit_lane == 2'd3) cnt++;
        end
        chk("lane3_once", cnt, 1);

        // Hit coincident with its own grant is queued, not dropped.
        cyc(1'b0, 1'b0, 4'b0100);
        cyc(1'b0, 1'b0, 4'b0100);
        chk("coin_lane_a", hit_lane, 2);
        chk("coin_hit_a", hit, 1);
        cyc(1'b0, 1'b0, 4'h0);
        chk("coin_lane_b", hit_lane, 2);
        chk("coin_hit_b", hit, 1);
        chk("coin_drop", drop_cnt, 1);
        cyc(1'b0, 1'b0, 4'h0);

        // Saturation: three drops per cycle for 100 cycles.
        repeat (100) cyc(1'b0, 1'b0, 4'hF);
        chk("sat_drop", drop_cnt, 255);
        repeat (6) cyc(1'b0, 1'b0, 4'h0);

        // Session end with lanes 2,3 captured on the final tick.
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);
        chk("ticks_1", ticks_left, 1);
        cyc(1'b0, 1'b1, 4'b1100);
        chk("drain_state", state, 3);
        chk("drain_ticks", ticks_left, 0);
        cnt = 0;
        cyc(1'b0, 1'b0, 4'hF);
        if (hit && hit_lane >= 2'd2) cnt++;
        cyc(1'b0, 1'b0, 4'hF);
        if (hit && hit_lane >= 2'd2) cnt++;
        cyc(1'b0, 1'b0, 4'h0);
        chk("drain_grants", cnt, 2);
        chk("done_state", state, 4);
        chk("done_flag", done, 1);
        chk("done_drop", drop_cnt, 255);
        cyc(1'b0, 1'b0, 4'hF);
        chk("done_nohit", hit, 0);
        cyc(1'b1, 1'b0, 4'h0);
        chk("restart_clear", state, 1);
        cyc(1'b0, 1'b0, 4'h0);
        chk("restart_drop", drop_cnt, 0);
        chk("restart_ticks", ticks_left, 3);

        // Abort mid-session.
        cyc(1'b0, 1'b0, 4'hF);
        mid_reset();
        chk("abort_state", state, 0);

        // Random traffic across many sessions with occasional aborts.
        for (int c = 0; c < 800; c++) begin
            cyc(($urandom_range(0, 11) == 0),
                ($urandom_range(0, 5) == 0),
                4'($urandom & $urandom));
            if (c % 200 == 199) mid_reset();
        end

        start = 1'b0; tick = 1'b0; lane_hit = 4'd0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_hit_scheduler.md
Name: score_hit_scheduler

Overview:
Game-session controller and lane arbiter in front of the single-hit score counter. It sequences a play session: idle, score clear, timed play, drain, then result hold. During a session it collects hit pulses from NUM_LANES button/judge lanes into per-lane pending flags. It grants them round-robin, at most one per cycle, onto the counter's one-cycle hit input, and counts hits it had to drop.

Parameters:
NUM_LANES, 4, number of hit lanes; fixed 4 in this revision, lane index 2 bits.
GAME_TICKS, 16'd30000, session length in i_Tick strobes; must be >= 1.
DROP_MAX, 8'd255, saturation value of the drop counter.

Ports:
i_Clk  input  1  system clock.
i_Rst  input  1  asynchronous active-high reset.
i_Start  input  1  session start pulse; honoured only in IDLE or DONE.
i_Tick  input  1  one-cycle time-base strobe (e.g. 1 ms).
i_LaneHit  input  4  per-lane one-cycle hit pulses; bit i = lane i.
o_ResetScore  output  1  score clear to counter; high exactly one cycle per session start.
o_Hit  output  1  one-cycle hit to counter.
o_HitLane  output  2  lane granted with o_Hit; 0 when o_Hit=0.
o_State  output  3  IDLE=0, CLEAR=1, PLAY=2, DRAIN=3, DONE=4.
o_Playing  output  1  high while state==PLAY.
o_Done  output  1  high while state==DONE.
o_TicksLeft  output  16  remaining ticks in session.
o_DropCnt  output  8  hits lost per session; saturates at DROP_MAX.

Behaviour:
- Reset (asynchronous, i_Rst high) puts every register in this state:
  - state=IDLE, pending=0, rr pointer=0.
  - o_Hit=0, o_HitLane=0, o_ResetScore=0, o_TicksLeft=0, o_DropCnt=0.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- IDLE: lane hits ignored. i_Start goes to CLEAR.
- CLEAR: lasts exactly one cycle, then PLAY.
  - o_ResetScore=1 while in CLEAR.
  - On the exit edge: pending cleared, o_DropCnt cleared, o_TicksLeft loaded with GAME_TICKS, rr pointer reset to 0.
- PLAY:
  - Each i_Tick decrements o_TicksLeft.
  - A tick with o_TicksLeft==1 sets it to 0 and moves to DRAIN on the same edge.
  - Hits sampled on that same edge are still accepted.
- DRAIN:
  - New lane hits are ignored and not counted as drops.
  - Remaining pending flags keep being granted.
  - When pending==0 and no grant is being issued, go to DONE.
- DONE: holds o_DropCnt and o_TicksLeft=0. i_Start goes to CLEAR. i_Start in CLEAR/PLAY/DRAIN is ignored.
- Pending capture (PLAY only): an edge with i_LaneHit[i]=1 sets pending[i].
- Arbitration (PLAY and DRAIN):
  - Each cycle with pending!=0, search lanes starting at the rr pointer, ascending and wrapping mod 4. The first pending lane g is granted.
  - On the next edge: o_Hit=1, o_HitLane=g, pending[g] cleared, rr pointer = (g+1) mod 4.
  - Latency: lane pulse at edge N sets pending; the earliest o_Hit is at edge N+1.
- Simultaneous set and clear: if lane g is granted on the same edge a new hit arrives on g, pending[g] stays 1. The new hit is queued, not dropped.
- Drop rule:
  - A hit on lane i while pending[i]=1 and i is not granted that edge is dropped.
  - o_DropCnt increments by the number of lanes dropped that edge, saturating at DROP_MAX.
- o_Hit is never high in IDLE, CLEAR or DONE. There is at most one grant per cycle.
- Asserting i_Rst mid-session aborts immediately to the reset state. No o_ResetScore pulse is generated; the counter has its own reset.

Test Plan:
1. Reset, then i_LaneHit=4'b1111 pulses in IDLE -> o_Hit stays 0, o_State=0, o_DropCnt=0.
2. i_Start at edge N -> o_State=1 and o_ResetScore=1 for exactly cycle N..N+1; at edge N+1 o_State=2, o_TicksLeft=GAME_TICKS, o_Playing=1.
3. In PLAY with rr=0, i_LaneHit=4'b1111 for one cycle at edge N -> o_Hit=1 at edges N+1..N+4 with o_HitLane=0,1,2,3; o_DropCnt=0.
4. Round-robin: grant lane 1, then lanes 0 and 2 pulse together -> lane 2 granted first, lane 0 next.
5. Drop and saturation:
   - 4'b1111 at edge N, then lane 3 again at N+1 -> o_DropCnt=1 and lane 3 granted once.
   - Forcing 300 drops -> o_DropCnt=255.
   - Same-lane hit coincident with its grant -> no drop, lane granted twice.
6. GAME_TICKS=3: three i_Tick pulses with lanes 2,3 pending -> DRAIN after the 3rd tick. Lanes 2,3 are granted, hits during DRAIN are ignored, and the state reaches DONE with o_Done=1. i_Start then restarts via CLEAR with o_DropCnt=0.
